regfile_wr_arbiter: RTL and testbench

//  Shares the register file's single write port among NREQ writeback sources (ALU, load, move-immediate).

---
 rtl/rfarb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/regfile_wr_arbiter.sv | 116 +++++++++++
 tb/tb_regfile_wr_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rfarb_pkg.sv
// Shared types and sizing helpers for the register-file write arbiter.
package rfarb_pkg;

    localparam int unsigned RFARB_W = 8;
    localparam int unsigned RFARB_D = 3;

    typedef logic [RFARB_D-1:0] reg_addr_t;
    typedef logic [RFARB_W-1:0] word_t;

    typedef struct packed {
        reg_addr_t addr;
        word_t     data;
    } wr_req_t;

    // Counter width able to hold 0..maxwait.
    function automatic int unsigned cnt_width(int unsigned maxwait);
        return (maxwait < 1) ? 1 : $clog2(maxwait + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr_i and wraps modulo N.
module rr_arbiter #(
    parameter int unsigned N = 3,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    logic [PW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        // k runs 1..N so the last candidate examined is ptr_i itself.
        for (int unsigned k = 1; k <= N; k++) begin
            cand = PW'((32'(ptr_i) + k) % N);
            if (!any_o && valid_i[cand]) begin
                any_o       = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: round-robin grant, registered write, starvation flags.
// Optional write-in-flight forwarding is enabled by defining RFARB_FWD_EN.
module regfile_wr_arbiter
    import rfarb_pkg::*;
#(
    parameter int unsigned W       = RFARB_W,
    parameter int unsigned D       = RFARB_D,
    parameter int unsigned NREQ    = 3,
    parameter int unsigned MAXWAIT = 7
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic [NREQ-1:0]   ReqValid,
    input  logic [NREQ*D-1:0] ReqAddr,
    input  logic [NREQ*W-1:0] ReqData,
    output logic [NREQ-1:0]   ReqReady,
    output logic              WriteReg,
    output logic [D-1:0]      WReg,
    output logic [W-1:0]      WriteValue,
    output logic [NREQ-1:0]   Starve,
    input  logic [D-1:0]      RdAddr1,
    input  logic [D-1:0]      RdAddr2,
    output logic              FwdHit1,
    output logic              FwdHit2,
    output logic [W-1:0]      FwdVal1,
    output logic [W-1:0]      FwdVal2
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned CW = cnt_width(MAXWAIT);

    typedef struct packed {
        logic [D-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   win_idx;
    logic            any_grant;
    logic [PW-1:0]   ptr_q, ptr_d;
    wr_t             sel;
    logic            wen_q;
    wr_t             wr_q, wr_d;
    logic [CW-1:0]   cnt_q [NREQ];
    logic [CW-1:0]   cnt_d [NREQ];

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .valid_i (ReqValid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx),
        .any_o   (any_grant)
    );

    // Reset gates the grant so no handshake completes while the block is held in reset.
    assign ReqReady = Reset_n ? grant : '0;

    always_comb begin
        sel.addr = ReqAddr[int'(win_idx)*D +: D];
        sel.data = ReqData[int'(win_idx)*W +: W];
        ptr_d    = any_grant ? win_idx : ptr_q;
        wr_d     = any_grant ? sel : wr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (ReqValid[i] && !grant[i]) begin
                cnt_d[i] = (cnt_q[i] == CW'(MAXWAIT)) ? cnt_q[i] : cnt_q[i] + 1'b1;
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr_q <= PW'(NREQ - 1);
            wen_q <= 1'b0;
            wr_q  <= '0;
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            wen_q <= any_grant;
            wr_q  <= wr_d;
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            Starve[i] = (cnt_q[i] == CW'(MAXWAIT));
        end
    end

    assign WriteReg   = wen_q;
    assign WReg       = wr_q.addr;
    assign WriteValue = wr_q.data;

`ifdef RFARB_FWD_EN
    assign FwdHit1 = wen_q && (wr_q.addr == RdAddr1);
    assign FwdHit2 = wen_q && (wr_q.addr == RdAddr2);
    assign FwdVal1 = FwdHit1 ? wr_q.data : '0;
    assign FwdVal2 = FwdHit2 ? wr_q.data : '0;
`else
    logic unused_rd;
    assign unused_rd = ^{RdAddr1, RdAddr2};
    assign FwdHit1   = 1'b0;
    assign FwdHit2   = 1'b0;
    assign FwdVal1   = '0;
    assign FwdVal2   = '0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter; a second instance with MAXWAIT=1 exercises Starve.
module tb_regfile_wr_arbiter;

    localparam int unsigned W = 8;
    localparam int unsigned D = 3;
    localparam int unsigned NREQ = 3;

    logic              CLK = 1'b0;
    logic              Reset_n;
    logic [NREQ-1:0]   ReqValid;
    logic [NREQ*D-1:0] ReqAddr;
    logic [NREQ*W-1:0] ReqData;
    logic [NREQ-1:0]   ReqReady, ReqReady2;
    logic              WriteReg, WriteReg2;
    logic [D-1:0]      WReg, WReg2;
    logic [W-1:0]      WriteValue, WriteValue2;
    logic [NREQ-1:0]   Starve, Starve2;
    logic [D-1:0]      RdAddr1, RdAddr2;
    logic              FwdHit1, FwdHit2, FwdHit1b, FwdHit2b;
    logic [W-1:0]      FwdVal1, FwdVal2, FwdVal1b, FwdVal2b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    regfile_wr_arbiter #(.W(W), .D(D), .NREQ(NREQ), .MAXWAIT(7)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .ReqValid(ReqValid), .ReqAddr(ReqAddr),
        .ReqData(ReqData), .ReqReady(ReqReady), .WriteReg(WriteReg), .WReg(WReg),
        .WriteValue(WriteValue), .Starve(Starve), .RdAddr1(RdAddr1), .RdAddr2(RdAddr2),
        .FwdHit1(FwdHit1), .FwdHit2(FwdHit2), .FwdVal1(FwdVal1), .FwdVal2(FwdVal2)
    );

    regfile_wr_arbiter #(.W(W), .D(D), .NREQ(NREQ), .MAXWAIT(1)) dut_short (
        .CLK(CLK), .Reset_n(Reset_n), .ReqValid(ReqValid), .ReqAddr(ReqAddr),
        .ReqData(ReqData), .ReqReady(ReqReady2), .WriteReg(WriteReg2), .WReg(WReg2),
        .WriteValue(WriteValue2), .Starve(Starve2), .RdAddr1(RdAddr1), .RdAddr2(RdAddr2),
        .FwdHit1(FwdHit1b), .FwdHit2(FwdHit2b), .FwdVal1(FwdVal1b), .FwdVal2(FwdVal2b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [D-1:0] rr_addr [NREQ];
    logic [W-1:0] rr_data [NREQ];
    logic [NREQ-1:0] onehot;

    initial begin
        rr_addr = '{3'd1, 3'd2, 3'd4};
        rr_data = '{8'h10, 8'h20, 8'h40};
        Reset_n  = 1'b0;
        ReqValid = 3'b111;
        ReqAddr  = {3'd4, 3'd2, 3'd1};
        ReqData  = {8'h40, 8'h20, 8'h10};
        RdAddr1  = 3'd0;
        RdAddr2  = 3'd0;

        // 1: held in reset with all requests valid
        tick();
        tick();
        check_val("rst_ready", 32'(ReqReady), 32'h0);
        check_val("rst_wen", 32'(WriteReg), 32'h0);
        check_val("rst_starve", 32'(Starve), 32'h0);
        check_val("rst_wreg", 32'(WReg), 32'h0);
        check_val("rst_wval", 32'(WriteValue), 32'h0);
        Reset_n = 1'b1;
        #1;
        check_val("rel_starve2", 32'(Starve2), 32'h0);

        // 3: continuous round robin 0,1,2,0,1,2
        for (int k = 0; k < 6; k++) begin
            onehot = NREQ'(1) << (k % 3);
            check_val($sformatf("rr_ready%0d", k), 32'(ReqReady), 32'(onehot));
            tick();
            check_val($sformatf("rr_wen%0d", k), 32'(WriteReg), 32'h1);
            check_val($sformatf("rr_wreg%0d", k), 32'(WReg), 32'(rr_addr[k % 3]));
            check_val($sformatf("rr_wval%0d", k), 32'(WriteValue), 32'(rr_data[k % 3]));
            check_val($sformatf("rr_starve%0d", k), 32'(Starve), 32'h0);
            check_val($sformatf("rr_starve2_%0d", k), 32'(Starve2), 32'(~onehot & 3'b111));
        end
        ReqValid = 3'b000;
        tick();
        check_val("idle_wen", 32'(WriteReg), 32'h0);
        check_val("idle_hold", 32'(WReg), 32'h4);

        // 2: single source, ptr=2 so req1 is reached after skipping req0
        ReqAddr  = {3'd0, 3'd5, 3'd0};
        ReqData  = {8'h00, 8'hA5, 8'h00};
        ReqValid = 3'b010;
        #1;
        check_val("single_ready", 32'(ReqReady), 32'h2);
        tick();
        ReqValid = 3'b000;
        check_val("single_wen", 32'(WriteReg), 32'h1);
        check_val("single_wreg", 32'(WReg), 32'h5);
        check_val("single_wval", 32'(WriteValue), 32'hA5);
        tick();
        check_val("single_wen_off", 32'(WriteReg), 32'h0);
        check_val("single_hold", 32'(WriteValue), 32'hA5);

        // bring ptr to 0 with a lone req0 grant
        ReqValid = 3'b001;
        #1;
        check_val("ptr0_ready", 32'(ReqReady), 32'h1);
        tick();
        ReqValid = 3'b000;

        // 4: same address from req0 and req2, ptr=0 -> req2 first
        ReqAddr  = {3'd2, 3'd0, 3'd2};
        ReqData  = {8'h22, 8'h00, 8'h11};
        ReqValid = 3'b101;
        #1;
        check_val("same_ready_a", 32'(ReqReady), 32'h4);
        tick();
        ReqValid = 3'b001;
        #1;
        check_val("same_ready_b", 32'(ReqReady), 32'h1);
        check_val("same_wreg_a", 32'(WReg), 32'h2);
        check_val("same_wval_a", 32'(WriteValue), 32'h22);
        tick();
        ReqValid = 3'b000;
        check_val("same_wreg_b", 32'(WReg), 32'h2);
        check_val("same_wval_b", 32'(WriteValue), 32'h11);

        // 5: async reset while a write is in flight (ptr=0 -> req1 next)
        ReqAddr  = {3'd7, 3'd3, 3'd6};
        ReqData  = {8'h77, 8'h33, 8'h66};
        ReqValid = 3'b010;
        #1;
        check_val("ar_ready", 32'(ReqReady), 32'h2);
        tick();
        check_val("ar_wen_before", 32'(WriteReg), 32'h1);
        ReqValid = 3'b111;
        #2;
        Reset_n = 1'b0;
        #1;
        check_val("ar_wen_now", 32'(WriteReg), 32'h0);
        check_val("ar_ready_rst", 32'(ReqReady), 32'h0);
        #1;
        Reset_n = 1'b1;
        #1;
        check_val("ar_ptr_reset", 32'(ReqReady), 32'h1);
        check_val("ar_starve2", 32'(Starve2), 32'h0);
        tick();
        check_val("ar_cnt_reset", 32'(Starve2), 32'h6);
        check_val("ar_wreg", 32'(WReg), 32'h6);
        ReqValid = 3'b000;
        tick();

        // 6: forwarding of the write in flight; ptr=0 so req0 is the last candidate
        ReqAddr  = {3'd0, 3'd0, 3'd6};
        ReqData  = {8'h00, 8'h00, 8'h3C};
        RdAddr1  = 3'd6;
        RdAddr2  = 3'd1;
        ReqValid = 3'b001;
        tick();
        ReqValid = 3'b000;
        check_val("fwd_wen", 32'(WriteReg), 32'h1);
`ifdef RFARB_FWD_EN
        check_val("fwd_hit1", 32'(FwdHit1), 32'h1);
        check_val("fwd_val1", 32'(FwdVal1), 32'h3C);
`else
        check_val("fwd_hit1", 32'(FwdHit1), 32'h0);
        check_val("fwd_val1", 32'(FwdVal1), 32'h0);
`endif
        check_val("fwd_hit2", 32'(FwdHit2), 32'h0);
        check_val("fwd_val2", 32'(FwdVal2), 32'h0);
        tick();
        check_val("fwd_hit1_idle", 32'(FwdHit1), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
